// File: rtl/serial_parity_rx.sv
// serial_parity_rx: receives one serial frame and checks its even parity.
// Frame format: start bit (0), DATA_BITS data bits sent LSB-first, one even
// parity bit, then a stop bit (1). The receiver only advances on edges where
// in_valid=1.
//
// Optional feature: define ERR_COUNT_EN to build the saturating bad-frame
// counter. When it is undefined, err_count is tied to 0 and cnt_clr is ignored.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_bit     serial line bit, sampled when in_valid=1
//   in_valid   qualifies in_bit
//   cnt_clr    synchronous clear of err_count (wins over an increment)
//   data_out   last good data word
//   data_valid one-cycle pulse, data_out updated with a good frame
//   parity_err one-cycle pulse, parity mismatch
//   frame_err  one-cycle pulse, stop bit was 0
//   busy       high whenever the receiver is not idle
//   err_count  saturating count of bad frames
module serial_parity_rx #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_bit,
  input  logic                 in_valid,
  input  logic                 cnt_clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic [CNT_W-1:0]     err_count
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   acc_q, acc_d;
  logic                   perr_q, perr_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   dvalid_q, dvalid_d;
  logic                   perr_strb_q, perr_strb_d;
  logic                   ferr_strb_q, ferr_strb_d;
  logic                   busy_q, busy_d;

  // State register and all datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      acc_q       <= 1'b0;
      perr_q      <= 1'b0;
      data_q      <= '0;
      dvalid_q    <= 1'b0;
      perr_strb_q <= 1'b0;
      ferr_strb_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      perr_q      <= perr_d;
      data_q      <= data_d;
      dvalid_q    <= dvalid_d;
      perr_strb_q <= perr_strb_d;
      ferr_strb_q <= ferr_strb_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and output logic; strobes default low so they last one cycle
  // even when in_valid is gapped.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    perr_d      = perr_q;
    data_d      = data_q;
    dvalid_d    = 1'b0;
    perr_strb_d = 1'b0;
    ferr_strb_d = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        IDLE: begin
          if (!in_bit) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            acc_d     = 1'b0;
          end
        end
        DATA: begin
          // Loop-compare avoids an index wider than the shift register needs
          for (int unsigned i = 0; i < DATA_BITS; i++) begin
            if (bit_cnt_q == BIT_CNT_W'(i)) shift_d[i] = in_bit;
          end
          acc_d     = acc_q ^ in_bit;
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) state_d = PAR;
        end
        PAR: begin
          perr_d  = acc_q ^ in_bit;
          state_d = STOP;
        end
        STOP: begin
          state_d     = IDLE;
          perr_strb_d = perr_q;
          ferr_strb_d = !in_bit;
          if (in_bit && !perr_q) begin
            data_d   = shift_q;
            dvalid_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign data_out   = data_q;
  assign data_valid = dvalid_q;
  assign parity_err = perr_strb_q;
  assign frame_err  = ferr_strb_q;
  assign busy       = busy_q;

`ifdef ERR_COUNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             bad_frame_c;

  // One increment per bad frame, even if both errors fire together
  assign bad_frame_c = perr_strb_d | ferr_strb_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (cnt_clr) begin
      err_cnt_d = '0;
    end else if (bad_frame_c && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx (DATA_BITS=8, CNT_W=2). Expected
// values come from hand-computed vector tables and a tiny counter model that
// follows the ERR_COUNT_EN build option.
module tb_serial_parity_rx;

  localparam int unsigned DB = 8;
  localparam int unsigned CW = 2;

  logic          clk;
  logic          reset;
  logic          in_bit;
  logic          in_valid;
  logic          cnt_clr;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;
  logic [CW-1:0] err_count;

  int n_cmp;
  int n_bad;
  int exp_cnt;

  serial_parity_rx #(.DATA_BITS(DB), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .cnt_clr    (cnt_clr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         gap;
    logic       exp_dv;
    logic       exp_pe;
    logic       exp_fe;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bench-side model of the bad-frame counter
  task automatic model_cnt(input logic bad, input logic clr);
`ifdef ERR_COUNT_EN
    if (clr) exp_cnt = 0;
    else if (bad && exp_cnt < 3) exp_cnt++;
`else
    exp_cnt = 0;
`endif
  endtask

  // One valid sample followed by gap idle cycles; flags any early strobe or busy drop
  task automatic drive_bit(input logic b, input int gap, inout logic bad);
    in_valid = 1'b1;
    in_bit   = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_bit   = 1'b1;
    if (data_valid || parity_err || frame_err || !busy) bad = 1'b1;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      if (data_valid || parity_err || frame_err || !busy) bad = 1'b1;
    end
  endtask

  // Sends a whole frame; checks frame-internal behaviour and the stop-edge response
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int gap, input logic clr,
                            input logic e_dv, input logic e_pe, input logic e_fe,
                            input logic [7:0] e_data, input string nm);
    logic bad;
    bad = 1'b0;
    drive_bit(1'b0, gap, bad);
    for (int i = 0; i < 8; i++) drive_bit(d[i], gap, bad);
    drive_bit(p, gap, bad);
    chk({nm, " in-frame"}, 32'(bad), 32'd0);
    in_valid = 1'b1;
    in_bit   = s;
    cnt_clr  = clr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_bit   = 1'b1;
    cnt_clr  = 1'b0;
    model_cnt(e_pe | e_fe, clr);
    chk({nm, " strobes"}, 32'({data_valid, parity_err, frame_err}), 32'({e_dv, e_pe, e_fe}));
    chk({nm, " data_out"}, 32'(data_out), 32'(e_data));
    chk({nm, " busy"}, 32'(busy), 32'd0);
    chk({nm, " err_count"}, 32'(err_count), 32'(exp_cnt));
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    exp_cnt  = 0;
    reset    = 1'b1;
    in_bit   = 1'b1;
    in_valid = 1'b0;
    cnt_clr  = 1'b0;

    //          data  par   stop  gap dv    pe    fe    data_out
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{8'hA5, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[3] = '{8'h3C, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[4] = '{8'h81, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 8'h81};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h01};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 1, 1'b0, 1'b1, 1'b0, 8'h01};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset data_out", 32'(data_out), 32'd0);
    chk("reset strobes", 32'({data_valid, parity_err, frame_err}), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset err_count", 32'(err_count), 32'd0);

    // Idle-line samples must not start a frame
    in_valid = 1'b1;
    in_bit   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("idle busy", 32'(busy), 32'd0);

    // Table frames are sent back to back (start follows stop immediately)
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop, vecs[v].gap, 1'b0,
                 vecs[v].exp_dv, vecs[v].exp_pe, vecs[v].exp_fe, vecs[v].exp_data,
                 $sformatf("vec%0d", v));
    end
    @(posedge clk); #1;
    chk("strobe width", 32'({data_valid, parity_err, frame_err}), 32'd0);

    // Reset in the middle of a frame after 4 data bits
    begin
      logic dummy;
      dummy = 1'b0;
      drive_bit(1'b0, 0, dummy);
      for (int i = 0; i < 4; i++) drive_bit(i[0], 0, dummy);
    end
    #2;
    reset = 1'b1;
    #1;
    chk("midreset data_out", 32'(data_out), 32'd0);
    chk("midreset strobes", 32'({data_valid, parity_err, frame_err}), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset err_count", 32'(err_count), 32'd0);
    exp_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("postreset strobes", 32'({data_valid, parity_err, frame_err, busy}), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, "after-reset");

    // Saturation: five bad frames, then a sixth with cnt_clr on its stop edge
    for (int k = 0; k < 5; k++) begin
      send_frame(8'h0F, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A,
                 $sformatf("sat%0d", k));
    end
`ifdef ERR_COUNT_EN
    chk("saturated", 32'(err_count), 32'd3);
`else
    chk("no counter", 32'(err_count), 32'd0);
`endif
    send_frame(8'h0F, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, "clr-vs-inc");
    chk("clr result", 32'(err_count), 32'd0);

    // Stand-alone clear while idle after counting one more bad frame
    send_frame(8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, "one-more");
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    model_cnt(1'b0, 1'b1);
    chk("idle clr", 32'(err_count), 32'(exp_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
